// File: rtl/mfhwt_quad_pack.sv
// Raster-to-quad packer: buffers each even row as pixel pairs in a line
// buffer, then on the odd row emits one 64-bit 2x2 quad per pixel pair
// in the order {TL, TR, BL, BR}.
module mfhwt_quad_pack #(
  parameter int IMG_WIDTH = 320,
  parameter int ADDR_W    = 8
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        ivalid,
  input  logic        isof,
  input  logic [15:0] idata,
  output logic        ovalid,
  output logic        osof,
  output logic [63:0] odata
);

  localparam int COL_W = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int DEPTH = IMG_WIDTH / 2;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  logic [COL_W-1:0]  col_q, col_d, col_eff;
  logic              odd_q, odd_d, odd_eff;
  logic [15:0]       hold_q, hold_d;
  logic              first_q, first_d;
  logic              ovalid_q, ovalid_d;
  logic              osof_q, osof_d;
  logic [63:0]       odata_q, odata_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_data_q;
  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wr_data;

  // Position tracking, pair assembly and quad formation for each accepted pixel
  always_comb begin
    col_d    = col_q;
    odd_d    = odd_q;
    hold_d   = hold_q;
    first_d  = first_q;
    ovalid_d = 1'b0;
    osof_d   = 1'b0;
    odata_d  = odata_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    // A start-of-frame pixel is always row 0 / col 0, whatever came before.
    col_eff  = isof ? '0   : col_q;
    odd_eff  = isof ? 1'b0 : odd_q;
    addr     = ADDR_W'(col_eff >> 1);
    wr_data  = {hold_q, idata};
    if (ivalid) begin
      if (isof) first_d = 1'b1;
      if (!col_eff[0]) begin
        hold_d = idata;
        rd_en  = odd_eff;           // fetch the top pair while the left pixel arrives
      end else if (!odd_eff) begin
        wr_en  = 1'b1;              // store the top pair for the next row
      end else begin
        odata_d  = {rd_data_q, hold_q, idata};
        ovalid_d = 1'b1;
        osof_d   = first_q;
        first_d  = 1'b0;
      end
      if (col_eff == COL_LAST) begin
        col_d = '0;
        odd_d = ~odd_eff;
      end else begin
        col_d = col_eff + 1'b1;
        odd_d = odd_eff;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      col_q    <= '0;
      odd_q    <= 1'b0;
      hold_q   <= '0;
      first_q  <= 1'b0;
      ovalid_q <= 1'b0;
      osof_q   <= 1'b0;
      odata_q  <= '0;
    end else begin
      col_q    <= col_d;
      odd_q    <= odd_d;
      hold_q   <= hold_d;
      first_q  <= first_d;
      ovalid_q <= ovalid_d;
      osof_q   <= osof_d;
      odata_q  <= odata_d;
    end
  end

  // Line buffer: synchronous write and read; read data holds until the next read
  always_ff @(posedge iClk) begin
    if (wr_en) mem[addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[addr];
  end

  assign ovalid = ovalid_q;
  assign osof   = osof_q;
  assign odata  = odata_q;

endmodule

// File: tb/tb_mfhwt_quad_pack.sv
// Bench for mfhwt_quad_pack: random and directed raster streams against a
// row-buffer reference model of the 2x2 quad packing.
module tb_mfhwt_quad_pack;

  localparam int W = 4;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        ivalid = 1'b0;
  logic        isof = 1'b0;
  logic [15:0] idata = '0;
  logic        ovalid;
  logic        osof;
  logic [63:0] odata;

  mfhwt_quad_pack #(.IMG_WIDTH(W), .ADDR_W(1)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .ivalid(ivalid), .isof(isof),
    .idata(idata), .ovalid(ovalid), .osof(osof), .odata(odata)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  // reference model: full previous even row kept, quads built from rows
  int          mrow, mcol;
  bit          mfirst;
  logic [15:0] top [W];
  logic [15:0] cur [W];
  logic [63:0] mlast;
  bit          ev, es;
  logic [63:0] ed;

  task automatic model_reset();
    mrow = 0; mcol = 0; mfirst = 0; mlast = '0;
  endtask

  // one accepted pixel; returns expected outputs one cycle later
  task automatic drive(input logic [15:0] d, input bit sof);
    ivalid = 1'b1; isof = sof; idata = d;
    @(posedge iClk); #1;
    ivalid = 1'b0; isof = 1'b0;
    ev = 0; es = 0;
    if (sof) begin mrow = 0; mcol = 0; mfirst = 1; end
    if (mrow % 2 == 0) top[mcol] = d;
    else begin
      cur[mcol] = d;
      if (mcol % 2 == 1) begin
        ev = 1; es = mfirst; mfirst = 0;
        mlast = {top[mcol-1], top[mcol], cur[mcol-1], cur[mcol]};
      end
    end
    ed = mlast;
    mcol++;
    if (mcol == W) begin mcol = 0; mrow++; end
  endtask

  task automatic idle();
    ivalid = 1'b0; isof = 1'b0; idata = 16'($urandom);
    @(posedge iClk); #1;
    ev = 0; es = 0; ed = mlast;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      ivalid = i[0]; isof = 1'b1; idata = 16'($urandom);
      @(posedge iClk); #1;
      checks++;
      if (ovalid !== 1'b0 || osof !== 1'b0 || odata !== 64'd0) begin
        errors++;
        $display("FAIL reset_hold c%0d: got v=%b s=%b d=%h, want 0 0 0", i, ovalid, osof, odata);
      end
    end
    ivalid = 1'b0; isof = 1'b0;
    iReset_n = 1'b1;
    model_reset();
    @(posedge iClk); #1;
  endtask

  task automatic test_frame();
    logic [63:0] exp_q [4];
    int nq = 0;
    exp_q[0] = 64'h0000_0001_0010_0011; exp_q[1] = 64'h0002_0003_0012_0013;
    exp_q[2] = 64'h0020_0021_0030_0031; exp_q[3] = 64'h0022_0023_0032_0033;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) begin
        drive(16'(r * 16 + c), r == 0 && c == 0);
        checks++;
        if (ovalid !== ev || osof !== es || odata !== ed) begin
          errors++;
          $display("FAIL frame r%0d c%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h", r, c, ovalid, osof, odata, ev, es, ed);
        end
        if (ovalid === 1'b1) begin
          checks++;
          if (nq > 3 || odata !== exp_q[nq] || osof !== (nq == 0)) begin
            errors++;
            $display("FAIL frame_const q%0d: got d=%h s=%b", nq, odata, osof);
          end
          nq++;
        end
      end
    checks++;
    if (nq != 4) begin errors++; $display("FAIL frame_count: got %0d want 4", nq); end
  endtask

  task automatic test_gaps();
    int nq = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) begin
        drive(16'(r * 16 + c), r == 0 && c == 0);
        checks++;
        if (ovalid !== ev || osof !== es || odata !== ed) begin
          errors++;
          $display("FAIL gaps r%0d c%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h", r, c, ovalid, osof, odata, ev, es, ed);
        end
        if (ovalid === 1'b1) nq++;
        for (int g = 0; g < 3; g++) begin
          idle();
          checks++;
          if (ovalid !== 1'b0 || osof !== 1'b0 || odata !== ed) begin
            errors++;
            $display("FAIL gaps_idle r%0d c%0d: got v=%b s=%b d=%h, want v=0 s=0 d=%h", r, c, ovalid, osof, odata, ed);
          end
        end
      end
    checks++;
    if (nq != 4) begin errors++; $display("FAIL gaps_count: got %0d want 4", nq); end
  endtask

  task automatic test_resof();
    bit seen = 0;
    for (int i = 0; i < W + 1; i++) begin
      drive(16'(16'h0100 + i), i == 0);
      checks++;
      if (ovalid !== ev || osof !== es || odata !== ed) begin
        errors++;
        $display("FAIL resof_a p%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h", i, ovalid, osof, odata, ev, es, ed);
      end
    end
    // row 1 col 1 arrives with isof: broken pair, pixel restarts a frame
    drive(16'h0bee, 1'b1);
    checks++;
    if (ovalid !== 1'b0) begin errors++; $display("FAIL resof_broken: got v=%b want 0", ovalid); end
    for (int i = 1; i < 2 * W; i++) begin
      drive(16'($urandom), 1'b0);
      checks++;
      if (ovalid !== ev || osof !== es || odata !== ed) begin
        errors++;
        $display("FAIL resof_b p%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h", i, ovalid, osof, odata, ev, es, ed);
      end
      if (ovalid === 1'b1 && !seen) begin
        seen = 1;
        checks++;
        if (odata[63:48] !== 16'h0bee || osof !== 1'b1) begin
          errors++;
          $display("FAIL resof_tl: got tl=%h s=%b, want tl=0bee s=1", odata[63:48], osof);
        end
      end
    end
  endtask

  task automatic test_short();
    int nq_a = 0, nq_b = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < (f == 0 ? 3 : 4) * W; i++) begin
        drive(16'($urandom), i == 0);
        checks++;
        if (ovalid !== ev || osof !== es || odata !== ed) begin
          errors++;
          $display("FAIL short f%0d p%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h", f, i, ovalid, osof, odata, ev, es, ed);
        end
        if (ovalid === 1'b1) begin if (f == 0) nq_a++; else nq_b++; end
      end
    checks++;
    if (nq_a != 2 || nq_b != 4) begin
      errors++;
      $display("FAIL short_count: got %0d/%0d want 2/4", nq_a, nq_b);
    end
  endtask

  task automatic test_back_to_back();
    int nq = 0, ns = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 4 * W; i++) begin
        drive(16'($urandom), i == 0);
        checks++;
        if (ovalid !== ev || osof !== es || odata !== ed) begin
          errors++;
          $display("FAIL b2b f%0d p%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h", f, i, ovalid, osof, odata, ev, es, ed);
        end
        if (ovalid === 1'b1) nq++;
        if (osof === 1'b1) ns++;
      end
    checks++;
    if (nq != 12 || ns != 3) begin
      errors++;
      $display("FAIL b2b_count: got q=%0d s=%0d want 12 3", nq, ns);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(16'($urandom), i == 0 || $urandom_range(0, 39) == 0);
      checks++;
      if (ovalid !== ev || osof !== es || odata !== ed) begin
        errors++;
        $display("FAIL random p%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h", i, ovalid, osof, odata, ev, es, ed);
      end
      repeat ($urandom_range(0, 2)) begin
        idle();
        checks++;
        if (ovalid !== 1'b0 || odata !== ed) begin
          errors++;
          $display("FAIL random_idle p%0d: got v=%b d=%h, want v=0 d=%h", i, ovalid, odata, ed);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < W + 2; i++) drive(16'($urandom | 1), i == 0);
    checks++;
    if (ovalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got v=%b want 1", ovalid); end
    #2 iReset_n = 1'b0;
    #1;
    checks++;
    if (ovalid !== 1'b0 || osof !== 1'b0 || odata !== 64'd0) begin
      errors++;
      $display("FAIL rstmid_async: got v=%b s=%b d=%h, want 0 0 0", ovalid, osof, odata);
    end
    @(negedge iClk); iReset_n = 1'b1;
    model_reset();
    @(posedge iClk); #1;
    for (int i = 0; i < 2 * W; i++) begin
      drive(16'($urandom), 1'b0);
      checks++;
      if (ovalid !== ev || osof !== es || odata !== ed) begin
        errors++;
        $display("FAIL rstmid_after p%0d: got v=%b s=%b d=%h, want v=%b s=%b d=%h", i, ovalid, osof, odata, ev, es, ed);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge iClk);
    #1;
    test_reset();
    test_frame();
    test_gaps();
    test_resof();
    test_short();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
